llr_minmax_sequencer: RTL and testbench
=======================================

LLR_MINMAX_SEQUENCER -- requirements
Module: llr_minmax_sequencer

Interface
REQ-001 Parameter LLR_BIT, default 6, SHALL set the signed two's-complement LLR width.
REQ-002 Parameter NUM_IN, default 16, SHALL set the number of LLRs per reduction; it SHALL be even and at least 2.
REQ-003 Parameter IDX_BIT, default 4, SHALL set the index width; it SHALL be at least ceil(log2(NUM_IN)).
REQ-004 The block SHALL use one clock, CLK, and a synchronous active-high reset, RST.
REQ-005 CLK  in  1  rising-edge clock.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 START  in  1  begin one reduction; sampled only in IDLE.
REQ-008 DIN_A  in  LLR_BIT  signed LLR, element index 2k in beat k.
REQ-009 DIN_B  in  LLR_BIT  signed LLR, element index 2k+1 in beat k.
REQ-010 DIN_VALID  in  1  DIN_A/DIN_B valid.
REQ-011 DIN_READY  out  1  block accepts a beat.
REQ-012 MAX  out  LLR_BIT  signed maximum over the NUM_IN elements.
REQ-013 MIN  out  LLR_BIT  signed minimum over the NUM_IN elements.
REQ-014 MIN_IDX  out  IDX_BIT  index of MIN.
REQ-015 OUT_VALID  out  1  MAX/MIN/MIN_IDX valid.
REQ-016 OUT_READY  in  1  consumer accepts the result.
REQ-017 BUSY  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have three states: IDLE, ACC and OUT.
- IDLE->ACC on START.
- ACC->OUT on acceptance of beat NUM_IN/2-1.
- OUT->IDLE on OUT_VALID&&OUT_READY.
REQ-019 A beat SHALL be accepted only on a cycle with DIN_VALID&&DIN_READY; DIN_READY SHALL be 1 exactly in ACC.
REQ-020 A beat counter SHALL clear on entry to ACC, increment per accepted beat, and never wrap within a reduction.
REQ-021 Beat 0 SHALL load: max=max(A,B); min=min(A,B); idx=0 if A<=B, else 1.
REQ-022 Each beat k>0 SHALL form 3-input signed max/min of A, B and the accumulated value.
- max/min SHALL update in the same cycle.
REQ-023 MIN_IDX SHALL change only on strict less-than, so ties keep the earliest index.
- Priority: accumulator, then A, then B.
REQ-024 All comparisons SHALL be signed, with no saturation, widening or rounding; outputs are exact input values.
REQ-025 If the last beat is accepted on cycle t, OUT_VALID SHALL be 1 from cycle t+1.
REQ-026 While in OUT with OUT_READY low, MAX, MIN and MIN_IDX SHALL hold stable.
REQ-027 MAX, MIN and MIN_IDX SHALL keep their last value after the handshake until the next beat 0 is accepted.
REQ-028 START in ACC or OUT SHALL be ignored; START on the handshake cycle SHALL NOT be accepted, because IDLE is entered first.
REQ-029 DIN_VALID outside ACC SHALL be ignored, with no state change.
REQ-030 Gaps in DIN_VALID during ACC SHALL stall the reduction without altering accumulated values.
REQ-031 When NUM_IN=2, the single beat SHALL send the FSM ACC->OUT directly.

Reset
REQ-032 RST SHALL apply at the clock edge and take priority over all other inputs.
REQ-033 On RST the block SHALL go to IDLE with the beat counter at 0.
REQ-034 Reset values: MAX=0, MIN=0, MIN_IDX=0, OUT_VALID=0, DIN_READY=0, BUSY=0.
REQ-035 RST during ACC or OUT SHALL abandon the reduction with no partial result, and the block SHALL accept START on the cycle after RST deasserts.

Verification
REQ-036 With NUM_IN=4, START, then beats (3,-5) and (7,-5) back-to-back -> OUT_VALID one cycle after beat 1; MAX=7, MIN=-5, MIN_IDX=1 (tie kept earliest).
REQ-037 With NUM_IN=4, beats (-32,31) and (31,-32) -> MAX=31, MIN=-32, MIN_IDX=0 (signed extremes).
REQ-038 With NUM_IN=4, DIN_VALID low for 3 cycles between beats, OUT_READY low for 2 cycles -> results unchanged by the stall; outputs stable until the handshake; then IDLE with BUSY=0.
REQ-039 RST asserted after beat 0 with accumulated max=9 -> next cycle IDLE, all outputs 0; a fresh reduction (1,2),(0,4) gives MAX=4, MIN=0, MIN_IDX=2.
REQ-040 START and DIN_VALID are held in OUT and on the handshake cycle -> no beat is accepted and no new reduction starts; START in IDLE next cycle is accepted.

Source files
------------

// File: rtl/llr_minmax_sequencer.sv
// Streams NUM_IN signed LLRs, two per beat, and reduces them to max, min and the
// index of the earliest minimum. The result is presented with a valid/ready handshake.
module llr_minmax_sequencer #(
  parameter int LLR_BIT = 6,
  parameter int NUM_IN  = 16,
  parameter int IDX_BIT = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [LLR_BIT-1:0] DIN_A,
  input  logic [LLR_BIT-1:0] DIN_B,
  input  logic               DIN_VALID,
  output logic               DIN_READY,
  output logic [LLR_BIT-1:0] MAX,
  output logic [LLR_BIT-1:0] MIN,
  output logic [IDX_BIT-1:0] MIN_IDX,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic               BUSY
);

  localparam int HALF    = NUM_IN / 2;
  localparam int CNT_BIT = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_BIT-1:0] LAST_BEAT = CNT_BIT'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [CNT_BIT-1:0] beat_reg, beat_next;
  logic signed [LLR_BIT-1:0] max_reg, max_next;
  logic signed [LLR_BIT-1:0] min_reg, min_next;
  logic [IDX_BIT-1:0] idx_reg, idx_next;

  logic signed [LLR_BIT-1:0] a, b;
  logic [IDX_BIT-1:0] idx_a, idx_b;

  assign a = $signed(DIN_A);
  assign b = $signed(DIN_B);

  // Element indices of the current beat: A is 2k, B is 2k+1.
  assign idx_a = IDX_BIT'({beat_reg, 1'b0});
  assign idx_b = IDX_BIT'({beat_reg, 1'b1});

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      max_reg   <= '0;
      min_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      max_reg   <= max_next;
      min_reg   <= min_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    max_next   = max_reg;
    min_next   = min_reg;
    idx_next   = idx_reg;

    case (state_reg)
      IDLE: begin
        if (START) begin
          state_next = ACC;
          beat_next  = '0;
        end
      end

      ACC: begin
        if (DIN_VALID) begin
          if (beat_reg == '0) begin
            max_next = (a >= b) ? a : b;
            min_next = (a <= b) ? a : b;
            idx_next = (a <= b) ? idx_a : idx_b;
          end else begin
            if (a > max_next) max_next = a;
            if (b > max_next) max_next = b;
            // Strict compares in accumulator, A, B order keep the earliest index on ties.
            if (a < min_next) begin
              min_next = a;
              idx_next = idx_a;
            end
            if (b < min_next) begin
              min_next = b;
              idx_next = idx_b;
            end
          end

          if (beat_reg == LAST_BEAT) begin
            state_next = OUT;
          end else begin
            beat_next = beat_reg + CNT_BIT'(1);
          end
        end
      end

      OUT: begin
        if (OUT_READY) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign DIN_READY = (state_reg == ACC);
  assign OUT_VALID = (state_reg == OUT);
  assign BUSY      = (state_reg != IDLE);
  assign MAX       = max_reg;
  assign MIN       = min_reg;
  assign MIN_IDX   = idx_reg;

endmodule

// File: tb/tb_llr_minmax_sequencer.sv
// Self-checking bench: a prefix-reduction model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic including resets.
module tb_llr_minmax_sequencer;

  localparam int LB = 6;
  localparam int NI = 4;
  localparam int IB = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          START = 1'b0;
  logic [LB-1:0] DIN_A = '0;
  logic [LB-1:0] DIN_B = '0;
  logic          DIN_VALID = 1'b0;
  logic          DIN_READY;
  logic [LB-1:0] MAX;
  logic [LB-1:0] MIN;
  logic [IB-1:0] MIN_IDX;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic          BUSY;

  int tests = 0;
  int fails = 0;

  llr_minmax_sequencer #(.LLR_BIT(LB), .NUM_IN(NI), .IDX_BIT(IB)) dut (
    .CLK(CLK), .RST(RST), .START(START),
    .DIN_A(DIN_A), .DIN_B(DIN_B), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
    .MAX(MAX), .MIN(MIN), .MIN_IDX(MIN_IDX),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 collecting, 2 presenting. Results are max, min and
  // first position of the min over all elements received so far in this reduction.
  int m_mode = 0;
  int m_n = 0;
  int elems[NI];
  int m_max = 0;
  int m_min = 0;
  int m_idx = 0;

  task automatic reduce(input int cnt);
    m_max = elems[0];
    m_min = elems[0];
    m_idx = 0;
    for (int i = 1; i < cnt; i++) begin
      if (elems[i] > m_max) m_max = elems[i];
      if (elems[i] < m_min) begin
        m_min = elems[i];
        m_idx = i;
      end
    end
  endtask

  always @(posedge CLK) begin
    if (RST) begin
      m_mode = 0;
      m_n = 0;
      m_max = 0;
      m_min = 0;
      m_idx = 0;
    end else begin
      case (m_mode)
        0: if (START) begin
          m_mode = 1;
          m_n = 0;
        end
        1: if (DIN_VALID) begin
          elems[2*m_n]   = $signed(DIN_A);
          elems[2*m_n+1] = $signed(DIN_B);
          m_n++;
          reduce(2*m_n);
          if (m_n == NI/2) m_mode = 2;
        end
        default: if (OUT_READY) m_mode = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    check("cyc_out_valid", int'(OUT_VALID), int'(m_mode == 2));
    check("cyc_din_ready", int'(DIN_READY), int'(m_mode == 1));
    check("cyc_busy", int'(BUSY), int'(m_mode != 0));
    check("cyc_max", $signed(MAX), m_max);
    check("cyc_min", $signed(MIN), m_min);
    check("cyc_min_idx", int'(MIN_IDX), m_idx);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_red();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic beat(input int a, input int b);
    DIN_A = LB'(a);
    DIN_B = LB'(b);
    DIN_VALID = 1'b1;
    tick();
    DIN_VALID = 1'b0;
  endtask

  task automatic handshake();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
  endtask

  task automatic check_result(input string tag, input int mx, input int mn, input int ix);
    check({tag, "_valid"}, int'(OUT_VALID), 1);
    check({tag, "_max"}, $signed(MAX), mx);
    check({tag, "_min"}, $signed(MIN), mn);
    check({tag, "_idx"}, int'(MIN_IDX), ix);
  endtask

  initial begin
    tick();
    tick();
    RST = 1'b0;
    check("rst_max", $signed(MAX), 0);
    check("rst_min", $signed(MIN), 0);
    check("rst_idx", int'(MIN_IDX), 0);
    check("rst_valid", int'(OUT_VALID), 0);
    check("rst_ready", int'(DIN_READY), 0);
    check("rst_busy", int'(BUSY), 0);

    // Back-to-back beats, tie on the minimum keeps index 1.
    start_red();
    beat(3, -5);
    check("tie_early_valid", int'(OUT_VALID), 0);
    beat(7, -5);
    check_result("tie", 7, -5, 1);
    handshake();
    check("tie_idle", int'(BUSY), 0);

    // Signed extremes.
    start_red();
    beat(-32, 31);
    beat(31, -32);
    check_result("ext", 31, -32, 0);
    handshake();

    // Input gap and output back-pressure.
    start_red();
    beat(5, -3);
    tick();
    tick();
    tick();
    beat(-7, 2);
    tick();
    tick();
    check_result("stall", 5, -7, 2);
    handshake();
    check("stall_idle", int'(BUSY), 0);
    check("stall_hold_max", $signed(MAX), 5);

    // Reset mid-reduction, then a fresh reduction.
    start_red();
    beat(9, 1);
    check("pre_rst_max", $signed(MAX), 9);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abort_max", $signed(MAX), 0);
    check("abort_min", $signed(MIN), 0);
    check("abort_idx", int'(MIN_IDX), 0);
    check("abort_busy", int'(BUSY), 0);
    check("abort_valid", int'(OUT_VALID), 0);
    start_red();
    check("restart_busy", int'(BUSY), 1);
    beat(1, 2);
    beat(0, 4);
    check_result("fresh", 4, 0, 2);
    handshake();

    // START and DIN_VALID held through OUT and the handshake.
    start_red();
    beat(1, 1);
    beat(-1, -1);
    START = 1'b1;
    DIN_A = LB'(20);
    DIN_B = LB'(-20);
    DIN_VALID = 1'b1;
    tick();
    tick();
    check_result("hold", 1, -1, 2);
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    DIN_VALID = 1'b0;
    check("hs_start_ignored", int'(BUSY), 0);
    check("hs_max_kept", $signed(MAX), 1);
    tick();
    START = 1'b0;
    check("idle_start_taken", int'(DIN_READY), 1);
    beat(2, 3);
    beat(4, 5);
    check_result("after", 5, 2, 0);
    handshake();

    // Randomized traffic, narrow value range half the time to provoke ties.
    for (int c = 0; c < 4000; c++) begin
      RST       = ($urandom_range(0, 99) == 0);
      START     = ($urandom_range(0, 1) == 1);
      DIN_VALID = ($urandom_range(0, 9) < 7);
      OUT_READY = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) begin
        DIN_A = LB'($urandom);
        DIN_B = LB'($urandom);
      end else begin
        DIN_A = LB'(int'($urandom_range(0, 3)) - 2);
        DIN_B = LB'(int'($urandom_range(0, 3)) - 2);
      end
      tick();
    end
    RST = 1'b0;
    START = 1'b0;
    DIN_VALID = 1'b0;
    OUT_READY = 1'b0;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
